colour_stats_engine: RTL
========================

# colour_stats_engine

Parametrised per-colour pixel statistics accumulator for the camera image-processing pipeline. It sits after the per-pixel colour classifiers and takes one hit bit per colour channel per pixel. Per frame it accumulates pixel count, x-sum, y-sum and bounding box for each of NUM_CH channels. At end of frame it snapshots the results into a double-buffered register bank that the I2C or Avalon readout logic reads through an indexed port, with a frame-done pulse and frame sequence number.

## Interface
- NUM_CH, 3: number of colour channels; range 1..16.
- IMAGE_W, 640: pixels per line.
- IMAGE_H, 480: lines per frame.
- SUM_W, 32: x-sum and y-sum accumulator width, ≤32.
- CNT_W, 24: pixel-count accumulator width, ≤32.
- MIN_COUNT, 16: minimum channel count for the snapshot valid flag.
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pixel qualifier.
- pix_sop  in  1  first pixel of frame; sampled only with pix_valid.
- pix_eop  in  1  last pixel of frame; sampled only with pix_valid.
- pix_hit  in  NUM_CH  per-channel detect bits for the current pixel.
- rd_req  in  1  read strobe.
- rd_ch  in  4  channel index.
- rd_sel  in  3  field select.
- rd_data  out  32  registered read data.
- rd_valid  out  1  rd_data valid.
- frame_done  out  1  one-cycle pulse when a new snapshot is available.
- frame_seq  out  8  count of completed frames; wraps 255→0.
- frame_err  out  1  last completed frame had pixel count ≠ IMAGE_W*IMAGE_H.

## Operation
- Coordinates x, y are internal, 11 bits each.
  - A valid pixel with pix_sop is pixel (0,0).
  - Each subsequent valid pixel advances x. At x == IMAGE_W-1, x wraps to 0 and y increments.
  - y saturates at 2047.
- in_frame flag: set by valid sop, cleared by valid eop. Valid pixels while !in_frame and without sop are ignored entirely.
- Accumulation, per channel c, for every accepted pixel with pix_hit[c]=1:
  - count += 1; xsum += x; ysum += y.
  - xmin/xmax/ymin/ymax are updated.
  - Each accumulator saturates at its all-ones value and sets sticky sat[c] for the frame.
- Accept-with-sop: accumulators are cleared and the sop pixel is accumulated in the same cycle, as if from zero. A second sop mid-frame restarts the frame with no snapshot and no error flag.
- Bounding-box reset values: xmin=IMAGE_W-1, xmax=0, ymin=IMAGE_H-1, ymax=0.
- Accept-with-eop:
  - The eop pixel is included.
  - All channels are copied into the snapshot bank.
  - frame_seq increments.
  - frame_err is loaded with (total accepted pixels ≠ IMAGE_W*IMAGE_H).
  - sop and eop on the same pixel form a one-pixel frame: snapshot of that pixel, frame_err=1.
- Snapshot per channel: count, xsum, ysum, box, sat, and valid = (count ≥ MIN_COUNT).
  - For a channel with count==0, box fields read 0.
- Readout (rd_sel), all fields zero-extended to 32 bits:
  - 0: count.
  - 1: xsum.
  - 2: ysum.
  - 3: {5'b0, xmax, 5'b0, xmin}.
  - 4: {5'b0, ymax, 5'b0, ymin}.
  - 5: {16'b0, frame_seq, 5'b0, frame_err, sat, valid}.
  - 6–7: 0.
  - rd_ch ≥ NUM_CH returns 0.
- Reset (asynchronous, any time, including mid-frame):
  - Accumulators, snapshot bank, in_frame, frame_seq, frame_err, frame_done, rd_data and rd_valid all clear to 0.
  - The bounding-box accumulators take their reset values.
  - Pixels after reset are ignored until the next sop.

## Timing
- Accumulator update: same clock edge as the accepted pixel.
- Snapshot: written on the eop edge.
- frame_done: high for exactly the cycle after the eop edge. frame_seq and frame_err already show new values in that cycle.
- Read: rd_req sampled at edge N gives rd_data/rd_valid during cycle N+1. rd_valid is high for one cycle per request, with no back-pressure.
- Read in the same edge as the snapshot write returns the old snapshot value. The next read returns the new one.
- Back-to-back rd_req on consecutive cycles is supported at one result per cycle.
- Gaps in pix_valid are arbitrary and coordinates hold through them.
- No combinational path from any input to any output.

## Test plan
Bench parameters: IMAGE_W=8, IMAGE_H=4, NUM_CH=3, MIN_COUNT=2.
- Full 32-pixel frame, ch0 hit at (2,1),(5,1),(3,3):
  - frame_done pulses once, frame_seq=1, frame_err=0.
  - ch0: count=3, xsum=10, ysum=5, sel3=0x00050002, sel4=0x00030001, valid=1.
- Frame with no hits on ch2: ch2 count=0, sel3=0, sel4=0, valid=0. Request rd_ch=5, sel=0 returns 0.
- Short frame, eop at pixel 20, with random pix_valid gaps:
  - frame_err=1.
  - Stats equal those of the gap-free run.
  - Pixels before the first sop are ignored.
- One-pixel frame (sop & eop together, ch1 hit): ch1 count=1, box at (0,0), frame_err=1. Second sop mid-frame: no frame_done.
- rd_req on the eop edge returns the previous-frame count; the next-cycle read returns the new count. 256 frames wrap frame_seq to 0.
- CNT_W=4, ch0 hit on all 32 pixels: count=15, sat=1. Assert reset_n low mid-frame: all outputs 0 asynchronously; the next full frame gives frame_seq=1.

Source files
------------

// File: rtl/colour_stats_engine.sv
// Per-colour pixel statistics: per-frame count, coordinate sums and bounding box per channel,
// snapshotted at end of frame into a bank read through an indexed, registered port.
module colour_stats_engine #(
  parameter int NUM_CH    = 3,
  parameter int IMAGE_W   = 640,
  parameter int IMAGE_H   = 480,
  parameter int SUM_W     = 32,
  parameter int CNT_W     = 24,
  parameter int MIN_COUNT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_valid,
  input  logic              pix_sop,
  input  logic              pix_eop,
  input  logic [NUM_CH-1:0] pix_hit,
  input  logic              rd_req,
  input  logic [3:0]        rd_ch,
  input  logic [2:0]        rd_sel,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              frame_done,
  output logic [7:0]        frame_seq,
  output logic              frame_err
);

  localparam logic [10:0] XLAST     = 11'(IMAGE_W - 1);
  localparam logic [10:0] YLAST     = 11'(IMAGE_H - 1);
  localparam logic [31:0] FRAME_PIX = 32'(IMAGE_W * IMAGE_H);

  logic              r_inFrame;
  logic [10:0]       r_x, r_y;
  logic [31:0]       r_total;
  logic [CNT_W-1:0]  r_cnt   [NUM_CH];
  logic [SUM_W-1:0]  r_xsum  [NUM_CH];
  logic [SUM_W-1:0]  r_ysum  [NUM_CH];
  logic [10:0]       r_xmin  [NUM_CH];
  logic [10:0]       r_xmax  [NUM_CH];
  logic [10:0]       r_ymin  [NUM_CH];
  logic [10:0]       r_ymax  [NUM_CH];
  logic [NUM_CH-1:0] r_sat;

  logic [CNT_W-1:0]  r_snapCnt  [NUM_CH];
  logic [SUM_W-1:0]  r_snapXsum [NUM_CH];
  logic [SUM_W-1:0]  r_snapYsum [NUM_CH];
  logic [10:0]       r_snapXmin [NUM_CH];
  logic [10:0]       r_snapXmax [NUM_CH];
  logic [10:0]       r_snapYmin [NUM_CH];
  logic [10:0]       r_snapYmax [NUM_CH];
  logic [NUM_CH-1:0] r_snapSat;
  logic [NUM_CH-1:0] r_snapValid;

  logic              w_accept;
  logic [10:0]       w_px, w_py, w_nx, w_ny;
  logic [31:0]       w_totalBase, w_total;
  logic [CNT_W-1:0]  w_cnt   [NUM_CH];
  logic [SUM_W-1:0]  w_xsum  [NUM_CH];
  logic [SUM_W-1:0]  w_ysum  [NUM_CH];
  logic [SUM_W:0]    w_xsExt [NUM_CH];
  logic [SUM_W:0]    w_ysExt [NUM_CH];
  logic [10:0]       w_xmin  [NUM_CH];
  logic [10:0]       w_xmax  [NUM_CH];
  logic [10:0]       w_ymin  [NUM_CH];
  logic [10:0]       w_ymax  [NUM_CH];
  logic [NUM_CH-1:0] w_sat;
  logic [31:0]       w_rdData;

  // A sop pixel is always (0,0) and starts from cleared accumulators, even mid-frame.
  always_comb begin
    w_accept    = pix_valid & (pix_sop | r_inFrame);
    w_px        = pix_sop ? 11'd0 : r_x;
    w_py        = pix_sop ? 11'd0 : r_y;
    w_nx        = (w_px == XLAST) ? 11'd0 : w_px + 11'd1;
    w_ny        = (w_px == XLAST && w_py != 11'h7FF) ? w_py + 11'd1 : w_py;
    w_totalBase = pix_sop ? 32'd0 : r_total;
    w_total     = (&w_totalBase) ? w_totalBase : w_totalBase + 32'd1;
  end

  always_comb begin
    w_sat = pix_sop ? '0 : r_sat;
    for (int c = 0; c < NUM_CH; c++) begin
      w_cnt[c]   = pix_sop ? '0 : r_cnt[c];
      w_xsum[c]  = pix_sop ? '0 : r_xsum[c];
      w_ysum[c]  = pix_sop ? '0 : r_ysum[c];
      w_xmin[c]  = pix_sop ? XLAST : r_xmin[c];
      w_xmax[c]  = pix_sop ? 11'd0 : r_xmax[c];
      w_ymin[c]  = pix_sop ? YLAST : r_ymin[c];
      w_ymax[c]  = pix_sop ? 11'd0 : r_ymax[c];
      w_xsExt[c] = {1'b0, w_xsum[c]} + (SUM_W + 1)'(w_px);
      w_ysExt[c] = {1'b0, w_ysum[c]} + (SUM_W + 1)'(w_py);
      if (pix_hit[c]) begin
        if (&w_cnt[c]) w_sat[c] = 1'b1;
        else           w_cnt[c] = w_cnt[c] + CNT_W'(1);
        if (w_xsExt[c][SUM_W]) begin
          w_xsum[c] = '1;
          w_sat[c]  = 1'b1;
        end else begin
          w_xsum[c] = w_xsExt[c][SUM_W-1:0];
        end
        if (w_ysExt[c][SUM_W]) begin
          w_ysum[c] = '1;
          w_sat[c]  = 1'b1;
        end else begin
          w_ysum[c] = w_ysExt[c][SUM_W-1:0];
        end
        if (w_px < w_xmin[c]) w_xmin[c] = w_px;
        if (w_px > w_xmax[c]) w_xmax[c] = w_px;
        if (w_py < w_ymin[c]) w_ymin[c] = w_py;
        if (w_py > w_ymax[c]) w_ymax[c] = w_py;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inFrame <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_total   <= '0;
      r_sat     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c]  <= '0;
        r_xsum[c] <= '0;
        r_ysum[c] <= '0;
        r_xmin[c] <= XLAST;
        r_xmax[c] <= '0;
        r_ymin[c] <= YLAST;
        r_ymax[c] <= '0;
      end
    end else if (w_accept) begin
      r_inFrame <= ~pix_eop;
      r_x       <= w_nx;
      r_y       <= w_ny;
      r_total   <= w_total;
      r_sat     <= w_sat;
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c]  <= w_cnt[c];
        r_xsum[c] <= w_xsum[c];
        r_ysum[c] <= w_ysum[c];
        r_xmin[c] <= w_xmin[c];
        r_xmax[c] <= w_xmax[c];
        r_ymin[c] <= w_ymin[c];
        r_ymax[c] <= w_ymax[c];
      end
    end
  end

  // Snapshot takes the post-eop values; an empty channel reports a zero box.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done  <= 1'b0;
      frame_seq   <= '0;
      frame_err   <= 1'b0;
      r_snapSat   <= '0;
      r_snapValid <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_snapCnt[c]  <= '0;
        r_snapXsum[c] <= '0;
        r_snapYsum[c] <= '0;
        r_snapXmin[c] <= '0;
        r_snapXmax[c] <= '0;
        r_snapYmin[c] <= '0;
        r_snapYmax[c] <= '0;
      end
    end else begin
      frame_done <= w_accept & pix_eop;
      if (w_accept && pix_eop) begin
        frame_seq <= frame_seq + 8'd1;
        frame_err <= (w_total != FRAME_PIX);
        r_snapSat <= w_sat;
        for (int c = 0; c < NUM_CH; c++) begin
          r_snapCnt[c]   <= w_cnt[c];
          r_snapXsum[c]  <= w_xsum[c];
          r_snapYsum[c]  <= w_ysum[c];
          r_snapXmin[c]  <= (w_cnt[c] == '0) ? 11'd0 : w_xmin[c];
          r_snapXmax[c]  <= (w_cnt[c] == '0) ? 11'd0 : w_xmax[c];
          r_snapYmin[c]  <= (w_cnt[c] == '0) ? 11'd0 : w_ymin[c];
          r_snapYmax[c]  <= (w_cnt[c] == '0) ? 11'd0 : w_ymax[c];
          r_snapValid[c] <= (32'(w_cnt[c]) >= 32'(MIN_COUNT));
        end
      end
    end
  end

  always_comb begin
    w_rdData = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == 4'(c)) begin
        case (rd_sel)
          3'd0:    w_rdData = 32'(r_snapCnt[c]);
          3'd1:    w_rdData = 32'(r_snapXsum[c]);
          3'd2:    w_rdData = 32'(r_snapYsum[c]);
          3'd3:    w_rdData = {5'b0, r_snapXmax[c], 5'b0, r_snapXmin[c]};
          3'd4:    w_rdData = {5'b0, r_snapYmax[c], 5'b0, r_snapYmin[c]};
          3'd5:    w_rdData = {16'b0, frame_seq, 5'b0, frame_err, r_snapSat[c], r_snapValid[c]};
          default: w_rdData = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= w_rdData;
    end
  end

endmodule
